// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared RV32I constants, LSU state encoding and access checks
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  // Load/store funct3 encodings
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // High when the access can never reach memory: bad funct3 or misaligned.
  function automatic logic access_bad(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = (funct3 >= 3'd3);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (funct3[1:0])
      2'd1:    misaligned = addr_lo[0];
      2'd2:    misaligned = (addr_lo != 2'd0);
      default: misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// load_extend : lane extraction and sign/zero extension of a loaded word
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] w_shift;

  // Move the addressed byte lane down to bit 0
  assign w_shift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = w_shift;
    case (funct3)
      LB:      data = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
      LH:      data = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      LBU:     data = {{(XLEN-8){1'b0}},         w_shift[7:0]};
      LHU:     data = {{(XLEN-16){1'b0}},        w_shift[15:0]};
      default: data = w_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : load/store unit with byte-lane steering, misalignment
//                   detection, req/gnt/rvalid memory handshake and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  // Counter value on the last cycle allowed in REQ+WAIT
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYC - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic              w_bad;
  logic              w_timeout;
  logic [XLEN-1:0]   w_ext;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata;

  assign w_bad     = access_bad(req_we, req_funct3, req_addr[1:0]);
  assign w_timeout = (r_cnt == c_timeout_last);

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (r_addr[1:0]),
    .funct3  (r_funct3),
    .data    (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Completion events take priority over a timeout in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (req_valid) begin
          w_next = w_bad ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          w_next = r_we ? LSU_DONE : LSU_WAIT;
        end else if (w_timeout) begin
          w_next = LSU_DONE;
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid || w_timeout) begin
          w_next = LSU_DONE;
        end
      end
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 8'd0;
            r_err    <= w_bad;
            if (w_bad) begin
              r_rdata <= '0;
            end
          end
        end
        LSU_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (!mem_gnt && w_timeout) begin
            r_err <= 1'b1;
          end
        end
        LSU_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_rvalid) begin
            r_rdata <= w_ext;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Store steering: byte and half data are replicated across all lanes
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'd0: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == LSU_IDLE);
  assign mem_req   = (r_state == LSU_REQ);
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? w_be : 4'b0000;
  assign mem_wdata = mem_req ? w_wdata : '0;
  assign rsp_valid = (r_state == LSU_DONE);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : scoreboard bench for mem_access_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  rsp_t  sq[$];
  mreq_t mq[$];
  logic [31:0] m_rdata = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues
  rsp_t        mon_r;
  mreq_t       mon_m;
  logic [31:0] mon_last = 32'd0;
  logic        prev_req = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_last = 32'd0;
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (mq.size() == 0) begin
          fail_now("unexpected_mem_req", "got mem_req=1, expected no memory access");
        end else begin
          mon_m = mq.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
          chk("mem_addr", mem_addr, mon_m.addr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, mon_m.be});
          if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.wdata);
        end
      end
      prev_req = mem_req;
      if (rsp_valid) begin
        if (sq.size() == 0) begin
          fail_now("unexpected_rsp", "got rsp_valid=1, expected none");
        end else begin
          mon_r = sq.pop_front();
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_r.err});
          chk("rsp_cycle", cyc, mon_r.cyc);
          if (mon_r.chk_rdata) chk("rsp_rdata", rsp_rdata, mon_r.rdata);
        end
        mon_last = rsp_rdata;
      end else if (rsp_rdata !== mon_last) begin
        chk("rsp_rdata_hold", rsp_rdata, mon_last);
      end
    end
  end

  // Reference model of one load/store: legality, lane data and latency
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int g, input int r, input bit noise);
    int    sz, a, acc, n, s;
    logic  bad, tmo;
    logic [31:0] v;
    rsp_t  e;
    mreq_t m;
    sz  = 1 << f3[1:0];
    a   = int'(addr[1:0]);
    bad = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    bad = bad || ((a % sz) != 0);

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (noise) begin
      mem_gnt    = 1'($urandom % 2);
      mem_rvalid = 1'($urandom % 2);
      mem_rdata  = $urandom;
    end
    acc = cyc;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    if (bad) begin
      e.err = 1'b1; e.rdata = 32'd0; e.chk_rdata = 1'b1; e.cyc = acc + 1;
      m_rdata = 32'd0;
      sq.push_back(e);
    end else begin
      m.we    = we;
      m.addr  = {addr[31:2], 2'b00};
      m.be    = 4'(((1 << sz) - 1) << a);
      m.wdata = 32'd0;
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
      mq.push_back(m);

      tmo = (g >= TO) || (!we && (g + 1 + r) >= TO);
      if (tmo) begin
        e.err = 1'b1; e.rdata = m_rdata; e.chk_rdata = 1'b1; e.cyc = acc + 1 + TO;
      end else if (we) begin
        e.err = 1'b0; e.rdata = 32'd0; e.chk_rdata = 1'b0; e.cyc = acc + 2 + g;
      end else begin
        v = word >> (8 * a);
        s = 0;
        if (sz == 1) begin
          s = int'(v & 32'hFF);
          if (!f3[2] && s >= 128) s = s - 256;
          v = 32'(s);
        end else if (sz == 2) begin
          s = int'(v & 32'hFFFF);
          if (!f3[2] && s >= 32768) s = s - 65536;
          v = 32'(s);
        end
        m_rdata = v;
        e.err = 1'b0; e.rdata = v; e.chk_rdata = 1'b1; e.cyc = acc + 3 + g + r;
      end
      sq.push_back(e);

      for (int i = 0; i < g; i++) begin
        if (noise && g < 200) req_valid = 1'($urandom % 2);
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      if (!we && noise) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!we && !tmo) begin
        for (int i = 0; i < r; i++) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end

    n = 0;
    while (sq.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (sq.size() != 0) begin
      fail_now("rsp_missing", "got no rsp_valid within 400 cycles, expected one");
      sq.delete();
    end
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic stray_rvalid();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #(10 * 30000);
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    mreq_t       m;
    int          sz;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'd0, 32'h102, 32'h0, 32'h1280FF00, 0, 0, 1'b0);
    do_txn(1'b0, 3'd4, 32'h102, 32'h0, 32'h1280FF00, 0, 0, 1'b0);
    do_txn(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 300, 0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h40, 32'h0, 32'hDEADBEEF, 2, 2, 1'b0);
    stray_rvalid();
    @(posedge clk); #1;

    // Reset asserted while waiting for read data
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    m.we = 1'b0; m.addr = 32'h300; m.be = 4'hF; m.wdata = 32'd0;
    mq.push_back(m);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(posedge clk); #1;
    mem_gnt   = 1'b0;
    chk("wait_mem_req", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    m_rdata = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 3'd2, 32'h44, 32'h0, 32'h13579BDF, 1, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      we   = 1'($urandom % 2);
      f3   = we ? 3'($urandom % 4) : 3'($urandom % 8);
      addr = $urandom;
      sz   = 1 << f3[1:0];
      if ($urandom % 3 != 0) addr = addr & ~(32'(sz) - 32'd1);
      do_txn(we, f3, addr, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    if (mq.size() != 0) fail_now("mem_req_missing", "got fewer memory requests than expected");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the multicycle controller and the unified instruction/data memory. It accepts one load or store request from the controller's MEM_ADR/MEM_READ phase. It performs byte-lane steering for byte, half and word accesses and detects misalignment. It runs a req/gnt/rvalid handshake with the memory and returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- ADDR_W, 32, byte address width
- TIMEOUT_CYC, 255, max cycles in REQ+WAIT before abort (8-bit counter, 1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  controller request; accepted when req_ready=1
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; held until next rsp_valid
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal funct3 or timeout
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, {req_addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, latch we/funct3/addr/wdata and check legality.
  - Illegal load funct3: 3, 6, 7. Illegal store funct3: >=3.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned -> DONE with err=1 and rdata=0; no memory access.
  - Otherwise -> REQ.
- REQ: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata stable.
  - On mem_gnt: store -> DONE; load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid: extract lane, extend, register into rsp_rdata, -> DONE.
- DONE: rsp_valid=1 for exactly one cycle, then -> IDLE.
- Byte enables: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load: shift mem_rdata right by 8*addr[1:0]. LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passthrough.
- Timeout: counter clears on leaving IDLE and increments each cycle in REQ or WAIT. At TIMEOUT_CYC: -> DONE, err=1, mem_req drops, rsp_rdata unchanged.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
- req_valid outside IDLE is ignored (not queued).

## Timing
- Reset (async, any state): -> IDLE. req_ready=1; all other outputs 0; rsp_rdata=0. In-flight access is abandoned and mem_req drops immediately.
- Moore outputs, all derived from the state register.
- Store with gnt in first REQ cycle: accept at cycle 0, REQ cycle 1, rsp_valid cycle 2.
- Load with gnt cycle 1 and rvalid cycle 2: rsp_valid cycle 3.
- Error detected at accept: rsp_valid cycle 1.
- rvalid in the same cycle as gnt is not sampled; memory must return data no earlier than the cycle after gnt.
- Minimum spacing between accepted requests: 2 cycles (DONE, then IDLE).

## Structure
- Shared package riscv_pkg:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW
  - LSU state encoding (2 bits)
  - XLEN=32
- Sub-module load_extend: combinational lane extraction and sign/zero extension, inputs (rdata, addr[1:0], funct3). FSM, counter, store steering and legality check remain in mem_access_unit.

## Test plan
- SB addr 0x103, wdata 0x000000A5, gnt immediate -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100, rsp_valid at cycle 2, err=0.
- LB addr 0x102, rdata 0x1280FF00 returned 1 cycle after gnt -> rsp_rdata=0xFFFFFF80. LBU same access -> 0x00000080.
- LH addr 0x101 -> rsp_valid cycle 1, err=1, rsp_rdata=0, mem_req never asserted.
- LW addr 0x200, gnt held low 300 cycles -> rsp_err=1 at 255 cycles in REQ, mem_req deasserts, back to IDLE.
- LW addr 0x40, gnt at cycle 3, rvalid at cycle 6 with 0xDEADBEEF -> rsp_valid cycle 7, rsp_rdata=0xDEADBEEF. Stray rvalid at cycle 9 leaves rsp_rdata unchanged.
- rst_n low during WAIT -> mem_req/rsp_valid=0 and req_ready=1 immediately. Next LW completes normally.
